// File: rtl/bus_request_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU bus arbiter.
package ArbiterTypes;

    // Transfer phases of the APB-like bus.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } ArbState;

    // Which requester currently owns the bus.
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        LSU   = 2'd2
    } BusOwner;

    // Width of the consecutive-LSU-grant counter (covers STARVE_LIMIT 1..15).
    localparam int STARVE_CNT_WIDTH = 4;

    // Timeout counter width: one bit more than needed to count TIMEOUT_CYCLES.
    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/bus_request_arbiter_grant_selector.sv
// Combinational grant decision: LSU-first with a fetch starvation guard.
module bus_grant_selector
    import ArbiterTypes::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        fetch_req_i,
    input  logic                        lsu_req_i,
    input  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_i,
    output BusOwner                     grant_o,
    output logic [STARVE_CNT_WIDTH-1:0] starve_cnt_next_o
);

    localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_C   = STARVE_CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_WIDTH-1:0] CNT_ONE_C = STARVE_CNT_WIDTH'(1);

    // Pick the owner and the starvation counter value that follows the grant.
    always_comb begin
        grant_o           = NONE;
        starve_cnt_next_o = starve_cnt_i;
        if (fetch_req_i && lsu_req_i) begin
            if (starve_cnt_i == LIMIT_C) begin
                grant_o           = FETCH;
                starve_cnt_next_o = '0;
            end else begin
                grant_o = LSU;
                if (starve_cnt_i != '1) begin
                    starve_cnt_next_o = starve_cnt_i + CNT_ONE_C;
                end else begin
                    starve_cnt_next_o = starve_cnt_i;
                end
            end
        end else if (lsu_req_i) begin
            grant_o           = LSU;
            starve_cnt_next_o = '0;
        end else if (fetch_req_i) begin
            grant_o           = FETCH;
            starve_cnt_next_o = '0;
        end else begin
            grant_o           = NONE;
            starve_cnt_next_o = starve_cnt_i;
        end
    end

endmodule

// File: rtl/bus_request_arbiter.sv
// Shares one APB-like bus between the fetch unit and the load/store unit.
// Runs SETUP/ACCESS, latches the winner's payload, and reports timeouts.
module bus_request_arbiter
    import ArbiterTypes::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    output logic                  fetchDone,
    output logic                  fetchErr,
    output logic [DATA_WIDTH-1:0] fetchRdata,
    input  logic                  lsuReq,
    input  logic                  lsuWrite,
    input  logic [ADDR_WIDTH-1:0] lsuAddr,
    input  logic [DATA_WIDTH-1:0] lsuWdata,
    output logic                  lsuDone,
    output logic                  lsuErr,
    output logic [DATA_WIDTH-1:0] lsuRdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  select,
    output logic                  enable,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  ready
);

    localparam int TCNT_WIDTH = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TCNT_WIDTH-1:0] TCNT_LAST_C = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_WIDTH-1:0] TCNT_ONE_C  = TCNT_WIDTH'(1);

    ArbState                     state_q, state_d;
    BusOwner                     owner_q, owner_d;
    logic [STARVE_CNT_WIDTH-1:0] starve_q, starve_d;
    logic [TCNT_WIDTH-1:0]       tcnt_q, tcnt_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic                        write_q, write_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic                        select_q, select_d;
    logic                        enable_q, enable_d;
    logic                        fetch_done_q, fetch_done_d;
    logic                        fetch_err_q, fetch_err_d;
    logic [DATA_WIDTH-1:0]       fetch_rdata_q, fetch_rdata_d;
    logic                        lsu_done_q, lsu_done_d;
    logic                        lsu_err_q, lsu_err_d;
    logic [DATA_WIDTH-1:0]       lsu_rdata_q, lsu_rdata_d;

    BusOwner                     grant_s;
    logic [STARVE_CNT_WIDTH-1:0] starve_next_s;

    bus_grant_selector #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant_selector (
        .fetch_req_i      (fetchReq),
        .lsu_req_i        (lsuReq),
        .starve_cnt_i     (starve_q),
        .grant_o          (grant_s),
        .starve_cnt_next_o(starve_next_s)
    );

    // Next-state logic: protocol sequencing, payload capture and completion reporting.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        starve_d      = starve_q;
        tcnt_d        = tcnt_q;
        addr_d        = addr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        select_d      = select_q;
        enable_d      = enable_q;
        // Completion outputs are only non-zero for the single RESP cycle.
        fetch_done_d  = 1'b0;
        fetch_err_d   = 1'b0;
        fetch_rdata_d = '0;
        lsu_done_d    = 1'b0;
        lsu_err_d     = 1'b0;
        lsu_rdata_d   = '0;
        case (state_q)
            IDLE: begin
                if (grant_s != NONE) begin
                    owner_d  = grant_s;
                    starve_d = starve_next_s;
                    tcnt_d   = '0;
                    select_d = 1'b1;
                    enable_d = 1'b0;
                    state_d  = SETUP;
                    if (grant_s == LSU) begin
                        addr_d  = lsuAddr;
                        write_d = lsuWrite;
                        wdata_d = lsuWdata;
                    end else begin
                        addr_d  = fetchAddr;
                        write_d = 1'b0;
                        wdata_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                enable_d = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (ready) begin
                    select_d = 1'b0;
                    enable_d = 1'b0;
                    state_d  = RESP;
                    if (owner_q == FETCH) begin
                        fetch_done_d  = 1'b1;
                        fetch_rdata_d = rdata;
                    end else begin
                        lsu_done_d  = 1'b1;
                        lsu_rdata_d = write_q ? '0 : rdata;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TCNT_LAST_C)) begin
                    // No ready within the budget: close the transfer with an error, no data.
                    select_d = 1'b0;
                    enable_d = 1'b0;
                    state_d  = RESP;
                    if (owner_q == FETCH) begin
                        fetch_done_d = 1'b1;
                        fetch_err_d  = 1'b1;
                    end else begin
                        lsu_done_d = 1'b1;
                        lsu_err_d  = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_ONE_C;
                end
            end
            RESP: begin
                owner_d = NONE;
                state_d = IDLE;
            end
            default: begin
                owner_d  = NONE;
                select_d = 1'b0;
                enable_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= NONE;
            starve_q      <= '0;
            tcnt_q        <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            select_q      <= 1'b0;
            enable_q      <= 1'b0;
            fetch_done_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_rdata_q <= '0;
            lsu_done_q    <= 1'b0;
            lsu_err_q     <= 1'b0;
            lsu_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            starve_q      <= starve_d;
            tcnt_q        <= tcnt_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            select_q      <= select_d;
            enable_q      <= enable_d;
            fetch_done_q  <= fetch_done_d;
            fetch_err_q   <= fetch_err_d;
            fetch_rdata_q <= fetch_rdata_d;
            lsu_done_q    <= lsu_done_d;
            lsu_err_q     <= lsu_err_d;
            lsu_rdata_q   <= lsu_rdata_d;
        end
    end

    assign addr       = addr_q;
    assign select     = select_q;
    assign enable     = enable_q;
    assign write      = write_q;
    assign wdata      = wdata_q;
    assign fetchDone  = fetch_done_q;
    assign fetchErr   = fetch_err_q;
    assign fetchRdata = fetch_rdata_q;
    assign lsuDone    = lsu_done_q;
    assign lsuErr     = lsu_err_q;
    assign lsuRdata   = lsu_rdata_q;

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Directed plus randomized bench for bus_request_arbiter with a transaction-level model.
module tb_bus_request_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetchReq = 1'b0;
    logic [AW-1:0] fetchAddr = '0;
    logic          fetchDone, fetchErr;
    logic [DW-1:0] fetchRdata;
    logic          lsuReq = 1'b0;
    logic          lsuWrite = 1'b0;
    logic [AW-1:0] lsuAddr = '0;
    logic [DW-1:0] lsuWdata = '0;
    logic          lsuDone, lsuErr;
    logic [DW-1:0] lsuRdata;
    logic [AW-1:0] addr;
    logic          select, enable, write;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;
    logic          ready = 1'b0;

    bus_request_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchDone(fetchDone),
        .fetchErr(fetchErr), .fetchRdata(fetchRdata),
        .lsuReq(lsuReq), .lsuWrite(lsuWrite), .lsuAddr(lsuAddr), .lsuWdata(lsuWdata),
        .lsuDone(lsuDone), .lsuErr(lsuErr), .lsuRdata(lsuRdata),
        .addr(addr), .select(select), .enable(enable), .write(write), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: outstanding requests, their payloads, LSU win streak.
    bit          fetch_pend = 1'b0;
    bit          lsu_pend   = 1'b0;
    logic [31:0] f_addr  = '0;
    logic [31:0] l_addr  = '0;
    bit          l_write = 1'b0;
    logic [31:0] l_wdata = '0;
    int          lsu_streak = 0;
    int          obs_log[$];
    int          pat[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        fetchReq  = fetch_pend;
        fetchAddr = f_addr;
        lsuReq    = lsu_pend;
        lsuAddr   = l_addr;
        lsuWrite  = l_write;
        lsuWdata  = l_wdata;
    endtask

    task automatic new_fetch();
        fetch_pend = 1'b1;
        f_addr     = $urandom();
    endtask

    task automatic new_lsu();
        lsu_pend = 1'b1;
        l_addr   = $urandom();
        l_write  = 1'($urandom_range(0, 1));
        l_wdata  = $urandom();
    endtask

    // Called in an IDLE cycle (just after a rising edge) with requests driven.
    // Returns in the following IDLE cycle, just after its rising edge.
    task automatic run_xfer(input int waits, input bit early_ready, input logic [31:0] rd_val,
                            input string tag);
        int          owner;
        int          n_access;
        int          seen;
        bit          exp_to;
        bit          exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        // LSU first, unless fetch has waited through LIM LSU grants in a row.
        if (fetch_pend && lsu_pend) owner = (lsu_streak == LIM) ? 1 : 2;
        else if (lsu_pend)          owner = 2;
        else                        owner = 1;
        if (owner == 2 && fetch_pend) lsu_streak = (lsu_streak < 15) ? lsu_streak + 1 : 15;
        else                          lsu_streak = 0;
        exp_to   = (waits >= TO);
        exp_wr   = (owner == 2) && l_write;
        exp_addr = (owner == 1) ? f_addr : l_addr;
        exp_wd   = (owner == 2) ? l_wdata : 32'h0;
        exp_rd   = (exp_to || exp_wr) ? 32'h0 : rd_val;

        ready = early_ready;
        @(negedge clk);
        chk({tag, " idle"}, {60'h0, select, enable, fetchDone, lsuDone}, 64'h0);
        @(posedge clk); #1;
        ready = early_ready;
        @(negedge clk);
        chk({tag, " setup ctl"}, {60'h0, select, enable, fetchDone, lsuDone}, 64'h8);
        chk({tag, " setup addr"}, {31'h0, write, addr}, {31'h0, exp_wr, exp_addr});
        chk({tag, " setup wdata"}, {32'h0, wdata}, {32'h0, exp_wd});
        @(posedge clk); #1;
        n_access = exp_to ? TO : waits + 1;
        for (int i = 0; i < n_access; i++) begin
            ready = (!exp_to && i == waits);
            rdata = (!exp_to && i == waits) ? rd_val : $urandom();
            @(negedge clk);
            chk({tag, " access ctl"}, {60'h0, select, enable, fetchDone, lsuDone}, 64'hC);
            chk({tag, " access addr"}, {31'h0, write, addr}, {31'h0, exp_wr, exp_addr});
            @(posedge clk); #1;
        end
        ready = 1'b0;
        rdata = $urandom();
        @(negedge clk);
        seen = fetchDone ? 1 : (lsuDone ? 2 : 0);
        obs_log.push_back(seen);
        chk({tag, " resp ctl"}, {62'h0, select, enable}, 64'h0);
        chk({tag, " resp done"}, {62'h0, fetchDone, lsuDone},
            {62'h0, (owner == 1), (owner == 2)});
        chk({tag, " resp err"}, {62'h0, fetchErr, lsuErr},
            {62'h0, (owner == 1) && exp_to, (owner == 2) && exp_to});
        chk({tag, " resp rdata"}, {fetchRdata, lsuRdata},
            {(owner == 1) ? exp_rd : 32'h0, (owner == 2) ? exp_rd : 32'h0});
        if (owner == 1) fetch_pend = 1'b0;
        else            lsu_pend   = 1'b0;
        @(posedge clk); #1;
        drive_reqs();
    endtask

    initial begin
        // Reset state.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ctl", {58'h0, select, enable, write, fetchDone, lsuDone, fetchErr | lsuErr}, 64'h0);
        chk("reset addr", {32'h0, addr}, 64'h0);
        chk("reset data", {wdata, fetchRdata | lsuRdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: single fetch read, ready on first ACCESS cycle.
        fetch_pend = 1'b1; f_addr = 32'h0000_0400;
        drive_reqs();
        run_xfer(0, 1'b0, 32'hDEADBEEF, "t1_fetch");

        // 2: LSU write with two wait states.
        lsu_pend = 1'b1; l_addr = 32'h0000_1000; l_write = 1'b1; l_wdata = 32'h0000_55AA;
        drive_reqs();
        run_xfer(2, 1'b0, $urandom(), "t2_lsu_wr");

        // 3: both requesting continuously; LIM LSU grants then one fetch.
        obs_log.delete();
        for (int k = 0; k < 10; k++) begin
            if (!fetch_pend) new_fetch();
            if (!lsu_pend)   new_lsu();
            drive_reqs();
            run_xfer($urandom_range(0, 1), 1'b0, $urandom(), "t3_starve");
        end
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3 grant%0d", k), 64'(obs_log[k]), 64'(pat[k]));
        end
        // Fetch still pending from the last LSU request? Drain whatever is left.
        while (fetch_pend || lsu_pend) run_xfer(0, 1'b0, $urandom(), "t3_drain");

        // 4: LSU read that never sees ready times out after TO ACCESS cycles.
        lsu_pend = 1'b1; l_addr = 32'h0000_2000; l_write = 1'b0; l_wdata = 32'h1234_5678;
        drive_reqs();
        run_xfer(TO + 1, 1'b0, 32'hFFFF_FFFF, "t4_timeout");

        // 6: ready asserted in IDLE and SETUP must be ignored.
        fetch_pend = 1'b1; f_addr = 32'h0000_0800;
        drive_reqs();
        run_xfer(2, 1'b1, 32'hCAFE_F00D, "t6_early_rdy");

        // 5: reset in the middle of ACCESS.
        fetch_pend = 1'b1; f_addr = 32'h0000_0C00;
        drive_reqs();
        @(posedge clk); #1;
        chk("t5 in setup", {62'h0, select, enable}, 64'h2);
        @(posedge clk); #1;
        chk("t5 in access", {62'h0, select, enable}, 64'h3);
        #1 rst = 1'b0;
        #1 chk("t5 abort", {62'h0, select, enable}, 64'h0);
        fetch_pend = 1'b0; lsu_pend = 1'b0; lsu_streak = 0;
        drive_reqs();
        repeat (2) begin
            @(negedge clk);
            chk("t5 no done", {62'h0, fetchDone, lsuDone}, 64'h0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        fetch_pend = 1'b1; f_addr = 32'h0000_0D00;
        drive_reqs();
        run_xfer(1, 1'b0, 32'h0BAD_F00D, "t5_after");

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            int w;
            if (!fetch_pend && $urandom_range(0, 1) == 1) new_fetch();
            if (!lsu_pend && $urandom_range(0, 1) == 1)   new_lsu();
            if (!fetch_pend && !lsu_pend) begin
                if ($urandom_range(0, 1) == 1) new_fetch();
                else                           new_lsu();
            end
            drive_reqs();
            w = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, 3);
            run_xfer(w, 1'($urandom_range(0, 1)), $urandom(), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
